// File: rtl/instr_fetch3_buf.sv
// instr_fetch3_buf: fetch stage 3 (data read) with a decoupling FIFO towards instruction align.
// Captures a Fetch2 request into S1, composes parcels and valid mask the next cycle, pushes the
// group into a FIFO and drains it under valid/ready. Fetch2 is throttled by credit.
// Optional feature: define FETCH3_BYPASS_EN to forward S1 straight to the outputs when the
// FIFO is empty.
module instr_fetch3_buf #(
    parameter int unsigned FETCH_PARCELS = 2,
    parameter int unsigned BUF_DEPTH     = 4,
    parameter int unsigned PC_W          = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [PC_W-1:0]          i_pc,
    input  logic                     i_icache_miss,
    input  logic [16*FETCH_PARCELS-1:0] i_icache_miss_data,
    input  logic                     i_page_fault,
    input  logic [16*FETCH_PARCELS-1:0] i_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [PC_W-1:0]          o_pc,
    output logic [16*FETCH_PARCELS-1:0] o_parcels,
    output logic [FETCH_PARCELS-1:0] o_mask,
    output logic                     o_page_fault
);

    localparam int unsigned FW    = 16 * FETCH_PARCELS;
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ST_W  = (FETCH_PARCELS > 1) ? $clog2(FETCH_PARCELS) : 1;

    typedef struct packed {
        logic [PC_W-1:0]          pc;
        logic [FW-1:0]            parcels;
        logic [FETCH_PARCELS-1:0] mask;
        logic                     pf;
    } entry_t;

    logic                 s1_valid_q, s1_valid_d;
    logic [PC_W-1:0]      s1_pc_q, s1_pc_d;
    logic                 s1_miss_q, s1_miss_d;
    logic [FW-1:0]        s1_miss_data_q, s1_miss_data_d;
    logic                 s1_pf_q, s1_pf_d;
    entry_t               mem_q [BUF_DEPTH];
    entry_t               mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [ST_W-1:0]      start;
    logic [CNT_W:0]       occupancy;
    entry_t               comp;
    entry_t               sel;
    logic                 push;
    logic                 pop;

    // First valid parcel index from PC alignment; a single-parcel group always starts at 0.
    generate
        if (FETCH_PARCELS > 1) begin : g_start
            assign start = s1_pc_q[ST_W:1];
        end else begin : g_start_one
            assign start = '0;
        end
    endgenerate

    // Compose the S1 group: refill/array data mux, page-fault squash and valid-parcel mask.
    always_comb begin
        comp         = '0;
        comp.pc      = s1_pc_q;
        comp.parcels = s1_pf_q ? '0 : (s1_miss_q ? s1_miss_data_q : i_data);
        comp.pf      = s1_pf_q;
        for (int unsigned k = 0; k < FETCH_PARCELS; k++) begin
            comp.mask[k] = (k >= 32'(start));
        end
    end

    // Credit from registers only: S1 reserves a slot, so a push never meets a full FIFO.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_valid_q};
    assign o_ready   = i_rst_n & (occupancy < (CNT_W + 1)'(BUF_DEPTH));
    assign pop       = (count_q != '0) & i_ready;

`ifdef FETCH3_BYPASS_EN
    // Empty FIFO: show S1 directly; it is only stored if IA does not take it this cycle.
    assign push    = s1_valid_q & ~((count_q == '0) & i_ready);
    assign sel     = ((count_q == '0) && s1_valid_q) ? comp : mem_q[rd_ptr_q];
    assign o_valid = (count_q != '0) | s1_valid_q;
`else
    assign push    = s1_valid_q;
    assign sel     = mem_q[rd_ptr_q];
    assign o_valid = (count_q != '0);
`endif

    assign o_pc         = sel.pc;
    assign o_parcels    = sel.parcels;
    assign o_mask       = sel.mask;
    assign o_page_fault = o_valid & sel.pf;

    // Next state: reset and flush override everything; reset also clears the storage.
    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_pc_d        = s1_pc_q;
        s1_miss_d      = s1_miss_q;
        s1_miss_data_d = s1_miss_data_q;
        s1_pf_d        = s1_pf_q;
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        if (!i_rst_n || i_flush) begin
            s1_valid_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            if (!i_rst_n) begin
                s1_pc_d        = '0;
                s1_miss_d      = 1'b0;
                s1_miss_data_d = '0;
                s1_pf_d        = 1'b0;
                for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                    mem_d[i] = '0;
                end
            end
        end else begin
            s1_valid_d = i_valid & o_ready;
            if (i_valid && o_ready) begin
                s1_pc_d        = i_pc;
                s1_miss_d      = i_icache_miss;
                s1_miss_data_d = i_icache_miss_data;
                s1_pf_d        = i_page_fault;
            end
            if (push) begin
                mem_d[wr_ptr_q] = comp;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers; reset is synchronous and folded into the next-state logic.
    always_ff @(posedge i_clk) begin
        s1_valid_q     <= s1_valid_d;
        s1_pc_q        <= s1_pc_d;
        s1_miss_q      <= s1_miss_d;
        s1_miss_data_q <= s1_miss_data_d;
        s1_pf_q        <= s1_pf_d;
        mem_q          <= mem_d;
        wr_ptr_q       <= wr_ptr_d;
        rd_ptr_q       <= rd_ptr_d;
        count_q        <= count_d;
    end

endmodule

// File: tb/tb_instr_fetch3_buf.sv
// Directed testbench for instr_fetch3_buf (default parameters: 2 parcels, depth 4, 32-bit PC).
// Expected latency follows FETCH3_BYPASS_EN: group visible 1 cycle after accept with bypass,
// 2 cycles without.
module tb_instr_fetch3_buf;

`ifdef FETCH3_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready_f2;
    logic [31:0] pc = '0;
    logic        miss = 1'b0;
    logic [31:0] miss_data = '0;
    logic        pf = 1'b0;
    logic [31:0] data = '0;
    logic        out_valid;
    logic        ia_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_parcels;
    logic [1:0]  out_mask;
    logic        out_pf;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch3_buf #(
        .FETCH_PARCELS(2),
        .BUF_DEPTH    (4),
        .PC_W         (32)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_flush           (flush),
        .i_valid           (in_valid),
        .o_ready           (out_ready_f2),
        .i_pc              (pc),
        .i_icache_miss     (miss),
        .i_icache_miss_data(miss_data),
        .i_page_fault      (pf),
        .i_data            (data),
        .o_valid           (out_valid),
        .i_ready           (ia_ready),
        .o_pc              (out_pc),
        .o_parcels         (out_parcels),
        .o_mask            (out_mask),
        .o_page_fault      (out_pf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; pc = 32'h9990; ia_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
            n_tests++;
            if (out_ready_f2 !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", out_ready_f2); end
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_ready_f2 !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", out_ready_f2); end
        n_tests++;
        if (out_valid !== 1'b0 || out_pf !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_valid_pf: got %b/%b want 0/0", out_valid, out_pf);
        end
        n_tests++;
        if (out_pc !== 32'h0 || out_parcels !== 32'h0 || out_mask !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_head: got pc=%h parcels=%h mask=%b want zeros", out_pc, out_parcels, out_mask);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_push: got valid %b want 0", out_valid); end
    endtask

    task automatic test_alignment;
        bit exp_v;
        ia_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c == 0); pc = 32'h1002; miss = 1'b0; pf = 1'b0;
            data = (c == 1) ? 32'hBBBB_AAAA : 32'h0;
            #1;
            exp_v = (c == LAT);
            n_tests++;
            if (out_valid !== exp_v) begin n_fail++; $display("FAIL align_valid c%0d: got %b want %b", c, out_valid, exp_v); end
            if (exp_v) begin
                n_tests++;
                if (out_pc !== 32'h1002 || out_mask !== 2'b10 || out_parcels !== 32'hBBBB_AAAA || out_pf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL align_group: got pc=%h mask=%b parcels=%h pf=%b want 1002/10/bbbbaaaa/0",
                             out_pc, out_mask, out_parcels, out_pf);
                end
            end
            tick();
        end
    endtask

    task automatic test_miss_pf;
        logic [31:0] g_pc   [2];
        logic [31:0] g_exp  [2];
        logic        g_pf   [2];
        int g;
        g_pc[0] = 32'h2000; g_exp[0] = 32'h1234_5678; g_pf[0] = 1'b0;
        g_pc[1] = 32'h2004; g_exp[1] = 32'h0;         g_pf[1] = 1'b1;
        ia_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid  = (c < 2);
            pc        = (c < 2) ? g_pc[c] : 32'h0;
            miss      = (c == 0);
            miss_data = (c == 0) ? 32'h1234_5678 : 32'h0BAD_0BAD;
            pf        = (c == 1);
            data      = (c == 1) ? 32'hDEAD_BEEF : ((c == 2) ? 32'hCAFE_F00D : 32'h0);
            #1;
            g = c - LAT;
            n_tests++;
            if (out_valid !== (g >= 0 && g < 2)) begin
                n_fail++; $display("FAIL misspf_valid c%0d: got %b want %b", c, out_valid, (g >= 0 && g < 2));
            end
            if (g >= 0 && g < 2) begin
                n_tests++;
                if (out_pc !== g_pc[g] || out_parcels !== g_exp[g] || out_pf !== g_pf[g] || out_mask !== 2'b11) begin
                    n_fail++;
                    $display("FAIL misspf_group%0d: got pc=%h parcels=%h pf=%b mask=%b want %h/%h/%b/11",
                             g, out_pc, out_parcels, out_pf, out_mask, g_pc[g], g_exp[g], g_pf[g]);
                end
            end
            tick();
        end
        miss = 1'b0; pf = 1'b0; miss_data = 32'h0;
    endtask

    task automatic test_back_to_back;
        int g;
        logic [1:0] exp_mask;
        ia_ready = 1'b1;
        for (int c = 0; c < 6 + LAT + 1; c++) begin
            in_valid = (c < 6);
            pc       = 32'h5000 + 32'(2 * c);
            data     = (c >= 1 && c <= 6) ? (32'hA000_0000 + 32'(c - 1)) : 32'h0;
            #1;
            if (c < 6) begin
                n_tests++;
                if (out_ready_f2 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready c%0d: got %b want 1", c, out_ready_f2); end
            end
            g = c - LAT;
            n_tests++;
            if (out_valid !== (g >= 0 && g < 6)) begin
                n_fail++; $display("FAIL b2b_valid c%0d: got %b want %b", c, out_valid, (g >= 0 && g < 6));
            end
            if (g >= 0 && g < 6) begin
                exp_mask = (g % 2 == 1) ? 2'b10 : 2'b11;
                n_tests++;
                if (out_pc !== 32'h5000 + 32'(2 * g) || out_parcels !== 32'hA000_0000 + 32'(g) || out_mask !== exp_mask) begin
                    n_fail++;
                    $display("FAIL b2b_group%0d: got pc=%h parcels=%h mask=%b want %h/%h/%b", g, out_pc,
                             out_parcels, out_mask, 32'h5000 + 32'(2 * g), 32'hA000_0000 + 32'(g), exp_mask);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        int accepted;
        int prev;
        accepted = 0; prev = -1;
        ia_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            pc       = 32'h3000 + 32'(4 * accepted);
            data     = (prev >= 0) ? (32'hD000_0000 + 32'(prev)) : 32'h0;
            #1;
            if (c >= 2) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_pc !== 32'h3000) begin
                    n_fail++; $display("FAIL bp_head_stable c%0d: got valid=%b pc=%h want 1/3000", c, out_valid, out_pc);
                end
            end
            if (out_ready_f2 === 1'b1) begin
                prev = accepted;
                accepted++;
            end else begin
                prev = -1;
            end
            if (c == 7) begin
                n_tests++;
                if (out_ready_f2 !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", out_ready_f2); end
            end
            tick();
        end
        n_tests++;
        if (accepted !== 4) begin n_fail++; $display("FAIL bp_accept_count: got %0d want 4", accepted); end
        in_valid = 1'b0; ia_ready = 1'b1; data = 32'h0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k < 4) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_pc !== 32'h3000 + 32'(4 * k) || out_parcels !== 32'hD000_0000 + 32'(k)) begin
                    n_fail++;
                    $display("FAIL bp_drain%0d: got valid=%b pc=%h parcels=%h want 1/%h/%h", k, out_valid, out_pc,
                             out_parcels, 32'h3000 + 32'(4 * k), 32'hD000_0000 + 32'(k));
                end
                n_tests++;
                if (out_ready_f2 !== (k != 0)) begin
                    n_fail++; $display("FAIL bp_drain_ready%0d: got %b want %b", k, out_ready_f2, (k != 0));
                end
            end else begin
                n_tests++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got valid %b want 0", out_valid); end
            end
            tick();
        end
    endtask

    task automatic test_flush;
        ia_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            pc       = 32'h6000 + 32'(4 * c);
            data     = (c >= 1) ? (32'hE000_0000 + 32'(c - 1)) : 32'h0;
            tick();
        end
        // Three groups buffered and one in S1; flush with a request and a pop offered.
        flush = 1'b1; in_valid = 1'b1; pc = 32'h7770; ia_ready = 1'b1; data = 32'hE000_0003;
        #1;
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
        tick();
        flush = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            in_valid = (c == 0);
            pc       = 32'h4440;
            data     = (c == 1) ? 32'h5555_6666 : 32'h0;
            #1;
            if (c == 0) begin
                n_tests++;
                if (out_ready_f2 !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", out_ready_f2); end
            end
            n_tests++;
            if (out_valid !== (c == LAT)) begin
                n_fail++; $display("FAIL flush_valid c%0d: got %b want %b", c, out_valid, (c == LAT));
            end
            if (c == LAT) begin
                n_tests++;
                if (out_pc !== 32'h4440 || out_parcels !== 32'h5555_6666 || out_mask !== 2'b11 || out_pf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_new_group: got pc=%h parcels=%h mask=%b pf=%b want 4440/55556666/11/0",
                             out_pc, out_parcels, out_mask, out_pf);
                end
            end
            tick();
        end
    endtask

    task automatic test_bypass;
        ia_ready = 1'b1;
        in_valid = 1'b1; pc = 32'h8006; data = 32'h0;
        tick();
        in_valid = 1'b0; data = 32'h7777_8888;
        #1;
        n_tests++;
        if (out_valid !== (LAT == 1)) begin n_fail++; $display("FAIL bypass_t1_valid: got %b want %b", out_valid, (LAT == 1)); end
        if (LAT == 1) begin
            n_tests++;
            if (out_pc !== 32'h8006 || out_parcels !== 32'h7777_8888 || out_mask !== 2'b10) begin
                n_fail++;
                $display("FAIL bypass_t1_group: got pc=%h parcels=%h mask=%b want 8006/77778888/10", out_pc, out_parcels, out_mask);
            end
        end
        tick();
        data = 32'h0;
        #1;
        n_tests++;
        if (out_valid !== (LAT == 2)) begin n_fail++; $display("FAIL bypass_t2_valid: got %b want %b", out_valid, (LAT == 2)); end
        if (LAT == 2) begin
            n_tests++;
            if (out_pc !== 32'h8006 || out_parcels !== 32'h7777_8888 || out_mask !== 2'b10) begin
                n_fail++;
                $display("FAIL bypass_t2_group: got pc=%h parcels=%h mask=%b want 8006/77778888/10", out_pc, out_parcels, out_mask);
            end
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || out_ready_f2 !== 1'b1) begin
            n_fail++; $display("FAIL bypass_empty_after: got valid=%b ready=%b want 0/1", out_valid, out_ready_f2);
        end
    endtask

    initial begin
        test_reset();
        test_alignment();
        test_miss_pf();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
